// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module      : la_pkg
// Description : Shared constants and capture FSM state type for the logic
//               analyser capture path, sample buffer and host link.
// Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

  localparam int LA_ADDR_W = 13;
  localparam int LA_DATA_W = 8;
  localparam int LA_DEPTH  = 1 << LA_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } cap_state_t;

  // Capture or readout in progress; ARM is not honoured in these states.
  function automatic logic state_is_busy(input cap_state_t s);
    return (s == S_ARMED) || (s == S_POST) ||
           (s == S_RD_ISSUE) || (s == S_RD_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/la_trig_match.sv
`default_nettype none
// ============================================================================
// Module      : la_trig_match
// Description : Combinational masked pattern compare. A probe bit only takes
//               part in the compare where its mask bit is set, so an all-zero
//               mask matches every sample.
// Revision    : 1.0 - initial release
// ============================================================================
module la_trig_match #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] probe_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  output logic              hit_o
);

  // Any masked bit that differs from the required value kills the match.
  always_comb begin
    hit_o = (((probe_i ^ trig_value_i) & trig_mask_i) == '0);
  end

endmodule
`default_nettype wire

// File: rtl/la_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : la_capture_ctrl
// Description : Writes probe samples into the sample buffer as a circular
//               history, waits for a masked trigger, records a programmed
//               number of post-trigger samples and then streams the captured
//               window, oldest sample first, over a valid/ready link. The
//               buffer's one-cycle read latency is absorbed by a two-step
//               issue/wait readout.
// Revision    : 1.0 - initial release
// ============================================================================
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              sample_en_i,
  input  logic [DATA_W-1:0] probe_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [ADDR_W-1:0] post_count_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o
);

  // Full-buffer fill count and unit steps, sized to avoid width mixing.
  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  cap_state_t        state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W:0]   fill_cnt_q,  fill_cnt_d;
  logic [ADDR_W-1:0] post_rem_q,  post_rem_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_W:0]   rd_cnt_q,    rd_cnt_d;
  logic              rd_valid_q,  rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              rd_last_q,   rd_last_d;
  logic              triggered_q, triggered_d;

  logic              trig_hit;
  logic              start_rd;

  la_trig_match #(
    .DATA_W (DATA_W)
  ) u_trig_match (
    .probe_i      (probe_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .hit_o        (trig_hit)
  );

  // State, pointer, counter and readout registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      post_rem_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_rem_q  <= post_rem_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      triggered_q <= triggered_d;
    end
  end

  // Next-state logic and buffer port drive; buffer outputs depend only on
  // registered state so RD_READY never reaches the RAM pins.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_rem_d  = post_rem_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    triggered_d = triggered_q;
    start_rd    = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          state_d     = S_ARMED;
          wr_ptr_d    = '0;
          fill_cnt_d  = '0;
          post_rem_d  = post_count_i;
          rd_ptr_d    = '0;
          rd_cnt_d    = '0;
          rd_valid_d  = 1'b0;
          rd_last_d   = 1'b0;
          triggered_d = 1'b0;
        end
      end

      S_ARMED, S_POST: begin
        ram_addr_o = wr_ptr_q;
        if (sample_en_i) begin
          ram_en_o   = 1'b1;
          ram_we_o   = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          fill_cnt_d = (fill_cnt_q == DEPTH_C) ? fill_cnt_q
                                               : fill_cnt_q + CNT_ONE;
          if (state_q == S_ARMED) begin
            // The trigger sample itself is kept as part of the window.
            if (trig_hit) begin
              triggered_d = 1'b1;
              if (post_rem_q == '0) begin
                start_rd = 1'b1;
              end else begin
                state_d = S_POST;
              end
            end
          end else begin
            post_rem_d = post_rem_q - PTR_ONE;
            if (post_rem_q == PTR_ONE) begin
              start_rd = 1'b1;
            end
          end
        end
      end

      S_RD_ISSUE: begin
        ram_en_o   = 1'b1;
        ram_addr_o = rd_ptr_q;
        state_d    = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (!rd_valid_q) begin
          // Buffer data for the read issued last cycle is on RAM_DOUT now.
          rd_valid_d = 1'b1;
          rd_data_d  = ram_dout_i;
          rd_last_d  = (rd_cnt_q == CNT_ONE);
        end else if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          rd_cnt_d   = rd_cnt_q - CNT_ONE;
          state_d    = rd_last_q ? S_DONE : S_RD_ISSUE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Window is the newest fill_cnt samples including this cycle's write;
    // a full buffer gives len low bits of zero so start equals wr_ptr.
    if (start_rd) begin
      state_d  = S_RD_ISSUE;
      rd_ptr_d = wr_ptr_d - fill_cnt_d[ADDR_W-1:0];
      rd_cnt_d = fill_cnt_d;
    end
  end

  assign ram_din_o   = probe_i;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;
  assign triggered_o = triggered_q;
  assign busy_o      = state_is_busy(state_q);
  assign done_o      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_la_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_capture_ctrl
// Description : Self-checking bench for la_capture_ctrl with a behavioural
//               sample buffer, a ready-stall driver and a window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_capture_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm_i;
  logic          sample_en_i;
  logic [DW-1:0] probe_i;
  logic [DW-1:0] trig_mask_i;
  logic [DW-1:0] trig_value_i;
  logic [AW-1:0] post_count_i;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_din_o;
  logic [DW-1:0] ram_dout_i;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;
  logic          rd_ready_i;
  logic          busy_o;
  logic          triggered_o;
  logic          done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  la_capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm_i        (arm_i),
    .sample_en_i  (sample_en_i),
    .probe_i      (probe_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .post_count_i (post_count_i),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_din_o    (ram_din_o),
    .ram_dout_i   (ram_dout_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o),
    .rd_ready_i   (rd_ready_i),
    .busy_o       (busy_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o)
  );

  // Behavioural 8K x 8 buffer with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en_o === 1'b1) begin
      if (ram_we_o === 1'b1) mem[ram_addr_o] <= ram_din_o;
      else                   ram_dout_i      <= mem[ram_addr_o];
    end
  end

  // Observers: accepted bytes, buffer accesses and stall stability.
  logic [DW-1:0] got_q[$];
  bit            got_last_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int            hs_total = 0;
  int            stab_err = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      pv = 1'b0;
    end else begin
      if (pv === 1'b1 && pr !== 1'b1) begin
        if (rd_valid_o !== 1'b1 || rd_data_o !== pd || rd_last_o !== pl)
          stab_err++;
      end
      if (rd_valid_o === 1'b1 && rd_ready_i === 1'b1) begin
        got_q.push_back(rd_data_o);
        got_last_q.push_back(rd_last_o === 1'b1);
        hs_total++;
      end
      if (ram_en_o === 1'b1) begin
        if (ram_we_o === 1'b1) wr_addr_q.push_back(ram_addr_o);
        else                   rd_addr_q.push_back(ram_addr_o);
      end
      pv = rd_valid_o;
      pr = rd_ready_i;
      pd = rd_data_o;
      pl = rd_last_o;
    end
  end

  // Ready driver: after each accepted byte, stall 0..stall_max cycles.
  int stall_max  = 0;
  bit ready_hold = 1'b0;
  int seen_hs    = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (hs_total != seen_hs) begin
      seen_hs    = hs_total;
      stall_left = int'($urandom_range(stall_max, 0));
    end
    rd_ready_i = !ready_hold && (stall_left == 0);
    if (stall_left > 0) stall_left--;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    arm_i       = 1'b0;
    sample_en_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic arm_pulse(input int post);
    post_count_i = AW'(post);
    arm_i        = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  function automatic logic [63:0] out_vec();
    return {36'd0, ram_en_o, ram_we_o, ram_addr_o, rd_valid_o, rd_data_o,
            rd_last_o, busy_o, triggered_o, done_o};
  endfunction

  logic [DW-1:0] samples[$];

  // One full capture of the global sample list, checked against a model
  // derived directly from the window rules.
  task automatic run_capture(input int post, input logic [DW-1:0] mask,
                             input logic [DW-1:0] value, input int en_pct,
                             input bit glitch, output bit wrapped);
    int k = -1;
    int n_feed, len, first, i, cyc, budget, hs_base, rd_base, wr_base;
    int stab_base, err, nlast, got_n;
    bit trig_pending = 1'b0;
    bit en;
    wrapped = 1'b0;
    for (int s = 0; s < samples.size(); s++) begin
      if (((samples[s] ^ value) & mask) == '0) begin
        k = s;
        break;
      end
    end
    if (k < 0) begin
      check("model_trigger_present", 0, 1);
      return;
    end
    n_feed = k + 1 + post;
    if (n_feed > samples.size()) begin
      check("model_enough_samples", samples.size(), n_feed);
      return;
    end
    len   = (n_feed < DEPTH) ? n_feed : DEPTH;
    first = n_feed - len;

    hs_base   = got_q.size();
    rd_base   = rd_addr_q.size();
    wr_base   = wr_addr_q.size();
    stab_base = stab_err;

    trig_mask_i  = mask;
    trig_value_i = value;
    arm_pulse(post);
    check("busy_after_arm", busy_o, 1);

    i      = 0;
    cyc    = 0;
    budget = n_feed * (300 / en_pct) + 100;
    while (i < n_feed && cyc < budget) begin
      en          = (int'($urandom_range(99, 0)) < en_pct);
      sample_en_i = en;
      probe_i     = en ? samples[i] : 8'($urandom);
      arm_i       = glitch && (i > k) && ($urandom_range(7, 0) == 0);
      if (en && i == k) begin
        check("trig_low_on_trigger_sample", triggered_o, 0);
        trig_pending = 1'b1;
      end
      if (en) i++;
      tick();
      cyc++;
      if (trig_pending) begin
        check("trig_rise_next_cycle", triggered_o, 1);
        trig_pending = 1'b0;
      end
    end
    if (i < n_feed) check("feed_timeout", i, n_feed);

    cyc    = 0;
    budget = len * (stall_max + 5) + 50;
    while (got_q.size() - hs_base < len && cyc < budget) begin
      sample_en_i = 1'($urandom);
      probe_i     = 8'($urandom);
      arm_i       = glitch && ($urandom_range(7, 0) == 0);
      tick();
      cyc++;
    end
    arm_i       = 1'b0;
    sample_en_i = 1'b0;
    check("readout_complete", got_q.size() - hs_base, len);
    check("done_after_last", done_o, 1);
    check("busy_low_in_done", busy_o, 0);
    check("triggered_held", triggered_o, 1);

    repeat (4) tick();
    got_n = got_q.size() - hs_base;
    check("no_extra_bytes", got_n, len);
    check("done_held", done_o, 1);

    err   = 0;
    nlast = 0;
    for (int j = 0; j < got_n && j < len; j++) begin
      if (got_q[hs_base + j] !== samples[first + j]) err++;
      if (got_last_q[hs_base + j]) nlast++;
    end
    check("window_content_errors", err, 0);
    check("last_count", nlast, 1);
    if (got_n > 0) check("last_on_final", got_last_q[hs_base + got_n - 1], 1);

    check("reads_per_byte", rd_addr_q.size() - rd_base, len);
    err = 0;
    for (int j = 0; j < rd_addr_q.size() - rd_base; j++) begin
      if (rd_addr_q[rd_base + j] !== AW'((first + j) % DEPTH)) err++;
      if (j > 0 && rd_addr_q[rd_base + j - 1] == AW'(DEPTH - 1) &&
          rd_addr_q[rd_base + j] == '0) wrapped = 1'b1;
    end
    check("read_addr_errors", err, 0);

    check("write_count", wr_addr_q.size() - wr_base, n_feed);
    err = 0;
    for (int j = 0; j < wr_addr_q.size() - wr_base; j++) begin
      if (wr_addr_q[wr_base + j] !== AW'(j % DEPTH)) err++;
    end
    check("write_addr_errors", err, 0);
    check("stall_stability_errors", stab_err - stab_base, 0);
  endtask

  typedef struct {
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    logic [DW-1:0] probe;
    bit            hit;
  } trig_vec_t;

  initial begin
    trig_vec_t vecs[9];
    bit        wrapped;
    int        base, waited;

    vecs[0] = '{8'hFF, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{8'hFF, 8'hA5, 8'hA4, 1'b0};
    vecs[2] = '{8'h0F, 8'h05, 8'hF5, 1'b1};
    vecs[3] = '{8'h0F, 8'h05, 8'hF4, 1'b0};
    vecs[4] = '{8'hF0, 8'hA0, 8'hAF, 1'b1};
    vecs[5] = '{8'hF0, 8'hA0, 8'hBF, 1'b0};
    vecs[6] = '{8'h00, 8'h5A, 8'hC3, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 8'h7F, 1'b0};
    vecs[8] = '{8'h01, 8'h01, 8'hFF, 1'b1};

    rst_n        = 1'b0;
    arm_i        = 1'b0;
    sample_en_i  = 1'b0;
    probe_i      = '0;
    trig_mask_i  = '0;
    trig_value_i = '0;
    post_count_i = '0;
    repeat (3) tick();
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", out_vec(), 0);

    // Trigger compare table, one single-sample capture per entry.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      trig_mask_i  = vecs[v].mask;
      trig_value_i = vecs[v].value;
      arm_pulse(0);
      sample_en_i = 1'b1;
      probe_i     = vecs[v].probe;
      tick();
      sample_en_i = 1'b0;
      check($sformatf("vec%0d_triggered", v), triggered_o, vecs[v].hit);
      if (vecs[v].hit) begin
        waited = 0;
        while (rd_valid_o !== 1'b1 && waited < 6) begin
          tick();
          waited++;
        end
        check($sformatf("vec%0d_rd_data", v), rd_data_o, vecs[v].probe);
        check($sformatf("vec%0d_rd_last", v), rd_last_o, 1);
      end else begin
        check($sformatf("vec%0d_still_armed", v), busy_o, 1);
      end
    end

    // Reset while a byte is being offered.
    do_reset();
    ready_hold   = 1'b1;
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h11;
    arm_pulse(0);
    sample_en_i = 1'b1;
    probe_i     = 8'h11;
    tick();
    sample_en_i = 1'b0;
    waited = 0;
    while (rd_valid_o !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check("midread_valid_reached", rd_valid_o, 1);
    rst_n = 1'b0;
    tick();
    check("midread_reset_outputs", out_vec(), 0);
    rst_n      = 1'b1;
    ready_hold = 1'b0;
    tick();
    check("midread_idle_after", out_vec(), 0);

    // 16 filler samples, A5 trigger, three post samples.
    stall_max = 0;
    samples.delete();
    for (int s = 0; s < 16; s++) samples.push_back(8'(s));
    samples.push_back(8'hA5);
    samples.push_back(8'h30);
    samples.push_back(8'h31);
    samples.push_back(8'h32);
    base = got_q.size();
    run_capture(3, 8'hFF, 8'hA5, 100, 1'b0, wrapped);
    check("post3_len", got_q.size() - base, 20);
    check("post3_byte17", got_q[base + 16], 8'hA5);

    // Randomised captures with stalls and stray ARM pulses.
    stall_max = 5;
    for (int r = 0; r < 6; r++) begin
      logic [DW-1:0] m, val;
      int            npre, npost;
      m     = 8'($urandom);
      val   = 8'($urandom);
      npre  = int'($urandom_range(40, 1));
      npost = int'($urandom_range(30, 0));
      samples.delete();
      for (int s = 0; s < npre; s++) samples.push_back(8'($urandom));
      samples.push_back((val & m) | (8'($urandom) & ~m));
      for (int s = 0; s < npost; s++) samples.push_back(8'($urandom));
      run_capture(npost, m, val, 60, 1'b1, wrapped);
    end

    // 10000 samples before the trigger: window wraps and keeps 8192.
    stall_max = 0;
    samples.delete();
    for (int s = 0; s < 10000; s++) samples.push_back(8'(s % 255));
    samples.push_back(8'hFF);
    base = got_q.size();
    run_capture(0, 8'hFF, 8'hFF, 100, 1'b0, wrapped);
    check("deep_len", got_q.size() - base, DEPTH);
    check("deep_first_is_1809", got_q[base], 8'(1809 % 255));
    check("deep_last_is_trigger", got_q[got_q.size() - 1], 8'hFF);
    check("deep_addr_wrap", wrapped, 1);

    // Maximum post count: window starts at the trigger sample.
    samples.delete();
    for (int s = 0; s < 5; s++) samples.push_back(8'(s));
    samples.push_back(8'hEE);
    for (int s = 0; s < 8191; s++) samples.push_back(8'(s % 200));
    base = got_q.size();
    run_capture(8191, 8'hFF, 8'hEE, 100, 1'b0, wrapped);
    check("maxpost_len", got_q.size() - base, DEPTH);
    check("maxpost_first_is_trigger", got_q[base], 8'hEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/la_capture_ctrl.md
# la_capture_ctrl

Capture controller that feeds the 8K×8 sample buffer, sitting directly upstream of it. It writes probe samples into the buffer as a circular history and detects a masked trigger pattern. It then records a programmable number of post-trigger samples and streams the captured window, oldest first, to the host link through a valid/ready handshake. It owns every buffer port, and the buffer's one-cycle read latency is absorbed here.

## Interface
- ADDR_W, 13: buffer address width; depth = 2**ADDR_W = 8192.
- DATA_W, 8: sample width.

- CLK  in  1  single clock for the whole block.
- RST_N  in  1  synchronous, active-low reset.
- ARM  in  1  one-cycle pulse that starts a capture; honoured in IDLE and DONE only.
- SAMPLE_EN  in  1  sample strobe from the rate divider.
- PROBE  in  DATA_W  probe inputs, already synchronised.
- TRIG_MASK  in  DATA_W  1 = bit participates in the trigger.
- TRIG_VALUE  in  DATA_W  required value of the masked bits.
- POST_COUNT  in  ADDR_W  samples kept after the trigger sample; latched on ARM.
- RAM_EN, RAM_WE  out  1  buffer enable and write enable.
- RAM_ADDR  out  ADDR_W  buffer address.
- RAM_DIN  out  DATA_W  buffer write data; equals PROBE.
- RAM_DOUT  in  DATA_W  buffer read data, valid one cycle after a read-enable cycle.
- RD_VALID  out  1  readout byte valid.
- RD_DATA  out  DATA_W  readout byte.
- RD_LAST  out  1  qualifies the final byte of the window.
- RD_READY  in  1  downstream accepts.
- BUSY  out  1  high in ARMED, POST and READ states.
- TRIGGERED  out  1  high from trigger until the next ARM or reset.
- DONE  out  1  high in DONE until the next ARM or reset.

## Operation
- States: IDLE, ARMED, POST, RD_ISSUE, RD_WAIT, DONE.
- IDLE/DONE → ARMED on ARM. The transition clears wr_ptr and fill_cnt, clears TRIGGERED and DONE, and latches POST_COUNT into post_rem.
- ARMED, cycle with SAMPLE_EN:
  - Write PROBE at wr_ptr (RAM_EN=RAM_WE=1), increment wr_ptr (wraps 8191→0), increment fill_cnt (saturates at 8192).
  - Trigger condition is ((PROBE ^ TRIG_VALUE) & TRIG_MASK) == 0, evaluated on the same sample. The trigger sample itself is written.
  - On trigger: if post_rem==0, go to RD_ISSUE; otherwise go to POST.
  - TRIG_MASK=0 triggers on the first sample.
- POST, cycle with SAMPLE_EN: write as in ARMED and decrement post_rem. At post_rem==1, the write completes and the FSM goes to RD_ISSUE.
- Sample windows:
  - POST_COUNT≥8191 keeps 8191 post samples plus the trigger sample.
  - Older samples are overwritten; the window is always the last fill_cnt samples.
- Readout window:
  - len = fill_cnt (1..8192); start = wr_ptr − len, modulo 8192.
  - rd_ptr starts at start; rd_cnt = len.
- RD_ISSUE:
  - Drive RAM_EN=1, RAM_WE=0, RAM_ADDR=rd_ptr, then go to RD_WAIT.
  - The cycle after entry, register RAM_DOUT into RD_DATA and set RD_VALID=1.
  - RD_LAST=1 when rd_cnt==1.
- RD_WAIT: RD_VALID is held and RD_DATA/RD_LAST are stable until RD_READY.
  - On handshake: RD_VALID drops, rd_ptr increments (wrapping) and rd_cnt decrements.
  - Then go to RD_ISSUE, or to DONE if RD_LAST was set.
- ARM while BUSY is ignored. SAMPLE_EN is ignored outside ARMED/POST; RAM_WE=0 in every other state.
- Reset (any state, including mid-readout with RD_VALID high):
  - Next cycle state is IDLE.
  - All outputs are 0: RAM_EN, RAM_WE, RAM_ADDR, RD_VALID, RD_DATA, RD_LAST, BUSY, TRIGGERED, DONE.
  - Pointers and counters are 0.

## Timing
- Capture write: combinational in the SAMPLE_EN cycle, one sample per clock maximum. The buffer latches it on that edge.
- TRIGGERED rises the cycle after the trigger sample.
- Readout:
  - RD_VALID rises 2 cycles after entering RD_ISSUE.
  - Throughput is one byte per 3 cycles with RD_READY held high.
  - No combinational path from RD_READY to RAM_*.
- DONE rises the cycle after the last handshake; BUSY falls in the same cycle.

## Structure
- Package la_pkg holds:
  - LA_ADDR_W=13, LA_DATA_W=8, LA_DEPTH=8192.
  - The state enum cap_state_t.
  - Shared with the buffer and the host-link blocks.
- Sub-module la_trig_match: combinational masked compare of PROBE/TRIG_MASK/TRIG_VALUE → hit. It is reused later for multi-stage triggers.
- Pointer/counter arithmetic is ADDR_W-bit, with natural wrap. fill_cnt is ADDR_W+1 bits.

## Test plan
- Reset mid-readout (RD_VALID=1) → next cycle IDLE, all outputs 0, RAM_WE=0.
- ARM, POST_COUNT=3, mask=FF value=A5; feed 0x00..0x0F then A5 at sample 16, then 3 samples. Required response:
  - TRIGGERED one cycle after A5.
  - len=20, readout 00..0F,A5,+3 samples.
  - RD_LAST on the 20th byte, then DONE.
- Fill 10000 samples (counter 0..) before the trigger, POST_COUNT=0. Required response:
  - Exactly 8192 bytes.
  - First byte = sample 1809 value, last = trigger sample.
  - Addresses wrap 8191→0.
- Random RD_READY stalls of 0–5 cycles → RD_DATA/RD_LAST stable while stalled, no byte lost or duplicated, one RAM read per accepted byte.
- POST_COUNT=8191, trigger at sample 5 → 8192 bytes; the first byte is the trigger sample.
- ARM pulses during POST and RD_WAIT → ignored. TRIG_MASK=0 → trigger on the first SAMPLE_EN; readout of 1 byte with RD_LAST=1.
